r200_id_stage: RTL
==================

# r200_id_stage

Pipelined, parametrised instruction-decode stage for the r200 core. Sits between fetch and execute. Decodes RV32I-style instructions, reads a configurable-depth register file, generates sign-extended immediates, and holds results in an ID/EX pipeline register behind a valid/ready handshake. Adds load-use stall detection, flush, and illegal-instruction flagging.

## Interface
- XLEN, 32, datapath width (32 or 64)
- NREG, 32, architectural register count; power of two, 2..32; AW = $clog2(NREG) derived
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  stage accepts the instruction this cycle
- if_pc  in  XLEN  PC of the presented instruction
- if_instr  in  32  presented instruction word
- flush  in  1  EX redirect; kill ID/EX contents
- wb_en / wb_addr / wb_data  in  1 / 5 / XLEN  register write-back port
- ex_valid  out  1  ID/EX register holds a live instruction
- ex_ready  in  1  EX consumes ID/EX this cycle
- ex_pc, ex_rs1, ex_rs2, ex_imm  out  XLEN  registered PC, operands, immediate
- ex_rd  out  5  destination address (0 if no write)
- ex_alu_op  out  4  {funct7[5], funct3}; forced to ADD for load/store/LUI/AUIPC/JAL/JALR
- ex_op1sel  out  1  0 = rs1, 1 = PC
- ex_op2sel  out  2  0 = rs2, 1 = imm, 2 = constant 4
- ex_memrd, ex_memwr, ex_regwr  out  1 each  control strobes
- ex_wbsel  out  2  0 = ALU, 1 = memory, 2 = PC+4
- ex_pcsel  out  2  0 = PC+4, 1 = branch, 2 = JAL, 3 = JALR
- ex_illegal  out  1  undecodable opcode or register index >= NREG

## Operation
- Opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111. Anything else: illegal.
- Immediates are I/S/B/U/J per type, sign-extended from instr[31] to XLEN. R-type imm = 0.
- Illegal instruction: all strobes (memrd, memwr, regwr) 0, ex_rd = 0, ex_illegal = 1, ex_valid still asserted.
- Register file: NREG×XLEN, index 0 reads 0, writes to 0 ignored. A write occurs at the clock edge when wb_en=1, wb_addr!=0 and wb_addr<NREG. Registers reset to 0.
- Load-use hazard: ex_valid & ex_memrd & ex_rd!=0 & (ex_rd==rs1 used | ex_rd==rs2 used). "Used" is by opcode: rs1 for all but LUI/AUIPC/JAL; rs2 for R/STORE/BRANCH.
- Load enable: load = ex_ready | ~ex_valid.
- if_ready = load & ~hazard, or 1 when flush=1.
- Next ex_valid:
  - flush → 0; the accepted instruction is discarded.
  - else if load & hazard → 0 (bubble).
  - else if load → if_valid; payload captured.
  - else hold all ID/EX contents.
- Payload registers update only on capture. Bubble and flush clear only ex_valid and the strobes.

## Timing
- Latency 1: an instruction accepted at edge N appears on ex_* after edge N. Full throughput with ex_ready held high.
- Register read is combinational from if_instr and captured at the accept edge.
- Reset: ex_valid=0 and all ex_* outputs 0. if_ready=1 after reset. Reset asserted mid-stall drops the stalled instruction.
- flush with ex_ready=0 still clears ex_valid. flush has priority over hazard.
- wb_en in the same cycle as the accept, same address:
  - with R200_ID_BYPASS_EN defined, the captured operand is wb_data;
  - otherwise it is the old value.

## Configuration
- R200_ID_BYPASS_EN defined: write-before-read bypass in the register-file read path (wb_addr==rs, wb_en, addr!=0).
- Undefined: no bypass. Write-back must then retire one cycle before a dependent decode; the hazard unit does not cover this case.

## Structure
- Package r200_pkg holds:
  - opcode localparams;
  - op2sel/wbsel/pcsel enum typedefs;
  - ALU_ADD constant;
  - an id_ex_t struct for the payload.
- Sub-module r200_gpr: register file parametrised by XLEN/NREG, with 2 read ports, 1 write port and the optional bypass.
- Decode, immediate generation and hazard logic stay inline.

## Test plan
- Reset, then addi x5,x0,-1 (0xFFF00293) with ex_ready=1 → next cycle ex_valid=1, ex_imm=all ones, ex_rd=5, ex_regwr=1, ex_op2sel=1.
- lw x3,0(x1) then add x4,x3,x2 back-to-back → if_ready=0 for one cycle, one bubble (ex_valid=0), then add is issued. Repeat with add x4,x0,x2 → no stall.
- ex_ready=0 for 3 cycles with if_valid=1 → ex_* stable, if_ready=0. Release → the next instruction is captured in one cycle.
- flush while ex_valid=1 and ex_ready=0 → ex_valid=0 next cycle, instruction on if_* dropped.
- wb_en=1, wb_addr=7, wb_data=0xDEADBEEF in the same cycle as decoding add x8,x7,x0 → ex_rs1=0xDEADBEEF with R200_ID_BYPASS_EN defined, 0 without it. Writes to x0 always read back 0.
- NREG=16: add x20,x1,x2 → ex_illegal=1, ex_regwr=0. Opcode 0x7F → ex_illegal=1.

Source files
------------

// File: rtl/r200_pkg.sv
// Shared decode constants, control-select enums and the ID/EX control payload
// for the r200 instruction-decode stage.
package r200_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  typedef enum logic [1:0] {OP2_RS2 = 2'd0, OP2_IMM = 2'd1, OP2_FOUR = 2'd2} op2sel_e;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wbsel_e;
  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_BRANCH = 2'd1, PC_JAL = 2'd2, PC_JALR = 2'd3} pcsel_e;

  // Control half of the ID/EX payload; XLEN-wide data fields live beside it.
  typedef struct packed {
    logic [4:0] rd;
    logic [3:0] alu_op;
    logic       op1sel;
    op2sel_e    op2sel;
    wbsel_e     wbsel;
    pcsel_e     pcsel;
    logic       illegal;
  } id_ex_t;

endpackage

// File: rtl/r200_id_stage_if.sv
// Fetch->ID and ID->EX channels. Handshake: a transfer happens on a rising edge
// where valid and ready are both 1; the master holds its payload while valid & ~ready.
interface r200_fetch_if #(parameter int XLEN = 32);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [31:0]     instr;
  modport master (output valid, pc, instr, input ready);
  modport slave  (input valid, pc, instr, output ready);
endinterface

interface r200_ex_if #(parameter int XLEN = 32);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc, rs1, rs2, imm;
  logic [4:0]      rd;
  logic [3:0]      alu_op;
  logic            op1sel;
  logic [1:0]      op2sel, wbsel, pcsel;
  logic            memrd, memwr, regwr, illegal;
  modport master (output valid, pc, rs1, rs2, imm, rd, alu_op, op1sel, op2sel, wbsel,
                  pcsel, memrd, memwr, regwr, illegal, input ready);
  modport slave  (input valid, pc, rs1, rs2, imm, rd, alu_op, op1sel, op2sel, wbsel,
                  pcsel, memrd, memwr, regwr, illegal, output ready);
endinterface

// File: rtl/r200_gpr.sv
// NREG x XLEN register file, two combinational read ports, one write port.
// Macro R200_ID_BYPASS_EN adds write-before-read forwarding on the read ports.
module r200_gpr #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd
);
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0] r_mem [NREG];
  logic            w_we;
  logic [XLEN-1:0] w_rd1, w_rd2;

  function automatic logic in_range(input logic [4:0] a);
    return ({27'd0, a} < 32'(NREG));
  endfunction

  assign w_we = i_we && (i_wa != 5'd0) && in_range(i_wa);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[i_wa[AW-1:0]] <= i_wd;
    end
  end

  // Out-of-range indices read 0; the decoder flags them illegal anyway.
  assign w_rd1 = (i_ra1 == 5'd0 || !in_range(i_ra1)) ? '0 : r_mem[i_ra1[AW-1:0]];
  assign w_rd2 = (i_ra2 == 5'd0 || !in_range(i_ra2)) ? '0 : r_mem[i_ra2[AW-1:0]];

`ifdef R200_ID_BYPASS_EN
  assign o_rd1 = (i_we && i_ra1 != 5'd0 && i_wa == i_ra1) ? i_wd : w_rd1;
  assign o_rd2 = (i_we && i_ra2 != 5'd0 && i_wa == i_ra2) ? i_wd : w_rd2;
`else
  assign o_rd1 = w_rd1;
  assign o_rd2 = w_rd2;
`endif

endmodule

// File: rtl/r200_id_stage.sv
// r200 decode stage: decode, immediates, register read, load-use stall, flush,
// ID/EX register. Optional R200_ID_BYPASS_EN enables write-back forwarding.
module r200_id_stage
  import r200_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  r200_fetch_if.slave     fetch,
  r200_ex_if.master       ex,
  input  logic            i_flush,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_addr,
  input  logic [XLEN-1:0] i_wb_data
);
  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1f, w_rs2f, w_rdf, w_rs1, w_rs2;
  logic            w_use1, w_use2, w_has_rd, w_known, w_illegal;
  logic            w_memrd, w_memwr, w_regwr, w_hazard, w_load;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_rd1, w_rd2;
  id_ex_t          w_ctl;

  logic            r_valid, r_memrd, r_memwr, r_regwr;
  logic [XLEN-1:0] r_pc, r_rs1, r_rs2, r_imm;
  id_ex_t          r_ctl;

  function automatic logic idx_ok(input logic [4:0] a);
    return ({27'd0, a} < 32'(NREG));
  endfunction

  assign w_opc  = fetch.instr[6:0];
  assign w_f3   = fetch.instr[14:12];
  assign w_rs1f = fetch.instr[19:15];
  assign w_rs2f = fetch.instr[24:20];
  assign w_rdf  = fetch.instr[11:7];

  always_comb begin
    w_ctl    = '0;
    w_use1   = 1'b0;
    w_use2   = 1'b0;
    w_has_rd = 1'b0;
    w_memrd  = 1'b0;
    w_memwr  = 1'b0;
    w_known  = 1'b1;
    w_imm32  = '0;
    case (w_opc)
      OPC_R: begin
        w_use1 = 1'b1; w_use2 = 1'b1; w_has_rd = 1'b1;
        w_ctl.alu_op = {fetch.instr[30], w_f3};
      end
      OPC_IALU: begin
        // Only SRAI carries funct7[5]; for other I-ALU ops bit 30 is immediate.
        w_use1 = 1'b1; w_has_rd = 1'b1;
        w_ctl.alu_op = {(w_f3 == 3'b101) & fetch.instr[30], w_f3};
        w_ctl.op2sel = OP2_IMM;
        w_imm32 = {{20{fetch.instr[31]}}, fetch.instr[31:20]};
      end
      OPC_LOAD: begin
        w_use1 = 1'b1; w_has_rd = 1'b1; w_memrd = 1'b1;
        w_ctl.op2sel = OP2_IMM; w_ctl.wbsel = WB_MEM;
        w_imm32 = {{20{fetch.instr[31]}}, fetch.instr[31:20]};
      end
      OPC_STORE: begin
        w_use1 = 1'b1; w_use2 = 1'b1; w_memwr = 1'b1;
        w_ctl.op2sel = OP2_IMM;
        w_imm32 = {{20{fetch.instr[31]}}, fetch.instr[31:25], fetch.instr[11:7]};
      end
      OPC_BRANCH: begin
        w_use1 = 1'b1; w_use2 = 1'b1;
        w_ctl.alu_op = {fetch.instr[30], w_f3};
        w_ctl.pcsel  = PC_BRANCH;
        w_imm32 = {{19{fetch.instr[31]}}, fetch.instr[31], fetch.instr[7],
                   fetch.instr[30:25], fetch.instr[11:8], 1'b0};
      end
      OPC_LUI: begin
        w_has_rd = 1'b1; w_ctl.op2sel = OP2_IMM;
        w_imm32 = {fetch.instr[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        w_has_rd = 1'b1; w_ctl.op1sel = 1'b1; w_ctl.op2sel = OP2_IMM;
        w_imm32 = {fetch.instr[31:12], 12'd0};
      end
      OPC_JAL: begin
        w_has_rd = 1'b1; w_ctl.op1sel = 1'b1; w_ctl.op2sel = OP2_FOUR;
        w_ctl.wbsel = WB_PC4; w_ctl.pcsel = PC_JAL;
        w_imm32 = {{11{fetch.instr[31]}}, fetch.instr[31], fetch.instr[19:12],
                   fetch.instr[20], fetch.instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        w_use1 = 1'b1; w_has_rd = 1'b1; w_ctl.op1sel = 1'b1; w_ctl.op2sel = OP2_FOUR;
        w_ctl.wbsel = WB_PC4; w_ctl.pcsel = PC_JALR;
        w_imm32 = {{20{fetch.instr[31]}}, fetch.instr[31:20]};
      end
      default: w_known = 1'b0;
    endcase
    w_illegal = !w_known || (w_use1 && !idx_ok(w_rs1f)) ||
                (w_use2 && !idx_ok(w_rs2f)) || (w_has_rd && !idx_ok(w_rdf));
    w_ctl.illegal = w_illegal;
    w_ctl.rd      = (w_has_rd && !w_illegal) ? w_rdf : 5'd0;
    w_regwr       = w_has_rd && !w_illegal;
  end

  // Unused source fields are read as x0 so their operands come out as zero.
  assign w_rs1 = w_use1 ? w_rs1f : 5'd0;
  assign w_rs2 = w_use2 ? w_rs2f : 5'd0;

  r200_gpr #(.XLEN(XLEN), .NREG(NREG)) u_gpr (
    .clk(clk), .rst_n(rst_n),
    .i_ra1(w_rs1), .i_ra2(w_rs2), .o_rd1(w_rd1), .o_rd2(w_rd2),
    .i_we(i_wb_en), .i_wa(i_wb_addr), .i_wd(i_wb_data)
  );

  assign w_hazard = r_valid && r_memrd && (r_ctl.rd != 5'd0) &&
                    ((w_use1 && r_ctl.rd == w_rs1f) || (w_use2 && r_ctl.rd == w_rs2f));
  assign w_load   = ex.ready || !r_valid;
  assign fetch.ready = i_flush || (w_load && !w_hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0; r_memrd <= 1'b0; r_memwr <= 1'b0; r_regwr <= 1'b0;
      r_pc <= '0; r_rs1 <= '0; r_rs2 <= '0; r_imm <= '0; r_ctl <= '0;
    end else if (i_flush || (w_load && w_hazard)) begin
      r_valid <= 1'b0; r_memrd <= 1'b0; r_memwr <= 1'b0; r_regwr <= 1'b0;
    end else if (w_load) begin
      r_valid <= fetch.valid;
      r_memrd <= fetch.valid && w_memrd && !w_illegal;
      r_memwr <= fetch.valid && w_memwr && !w_illegal;
      r_regwr <= fetch.valid && w_regwr;
      if (fetch.valid) begin
        r_pc  <= fetch.pc;
        r_rs1 <= w_rd1;
        r_rs2 <= w_rd2;
        r_imm <= XLEN'($signed(w_imm32));
        r_ctl <= w_ctl;
      end
    end
  end

  assign ex.valid   = r_valid;
  assign ex.pc      = r_pc;
  assign ex.rs1     = r_rs1;
  assign ex.rs2     = r_rs2;
  assign ex.imm     = r_imm;
  assign ex.rd      = r_ctl.rd;
  assign ex.alu_op  = r_ctl.alu_op;
  assign ex.op1sel  = r_ctl.op1sel;
  assign ex.op2sel  = r_ctl.op2sel;
  assign ex.wbsel   = r_ctl.wbsel;
  assign ex.pcsel   = r_ctl.pcsel;
  assign ex.illegal = r_ctl.illegal;
  assign ex.memrd   = r_memrd;
  assign ex.memwr   = r_memwr;
  assign ex.regwr   = r_regwr;

endmodule
